// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped UART transmit controller.
// Buffers CPU byte writes in a small TX FIFO and feeds them one at a time to
// an existing transmitter (tx_din / tx_wr_en / tx_busy), so the CPU no longer
// polls tx_busy per byte.
//
// Register map (CPU data bus):
//   BASE_ADDR+0  DATA    write-only, pushes a byte into the FIFO
//   BASE_ADDR+1  STATUS  {timeout_err, overflow, count[3:0], active, full}
//   BASE_ADDR+2  CTRL    {6'b0, irq_en, enable}; writing bit7=1 clears
//                        overflow and timeout_err (not stored)
//
// Ports:
//   clk, reset_               single clock, async active-low reset
//   m_addr/m_wr_data/m_wr/m_rd/m_en   CPU bus
//   m_rd_data, rd_hit         combinational read data and its "ours" flag
//   tx_din, tx_wr_en          registered byte + one-cycle start pulse
//   tx_busy                   transmitter busy
//   irq                       level interrupt: idle with FIFO drained
module uart_tx_ctrl #(
    parameter logic [10:0] BASE_ADDR    = 11'd101,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [10:0] m_addr,
    input  logic [7:0]  m_wr_data,
    input  logic        m_wr,
    input  logic        m_rd,
    input  logic        m_en,
    output logic [7:0]  m_rd_data,
    output logic        rd_hit,
    output logic [7:0]  tx_din,
    output logic        tx_wr_en,
    input  logic        tx_busy,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [10:0] STATUS_ADDR = BASE_ADDR + 11'd1;
    localparam logic [10:0] CTRL_ADDR   = BASE_ADDR + 11'd2;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   tmo_cnt;
    logic            enable, irq_en, overflow, timeout_err;
    logic            full, empty, pop, push, tmo_fire;
    logic            data_wr, ctrl_wr;
    logic [7:0]      status, ctrl;

    // ---- bus decode ----
    assign data_wr = m_en & m_wr & (m_addr == BASE_ADDR);
    assign ctrl_wr = m_en & m_wr & (m_addr == CTRL_ADDR);
    assign rd_hit  = m_en & m_rd & ((m_addr == STATUS_ADDR) | (m_addr == CTRL_ADDR));

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A pop only happens on data already held, so a push into an empty FIFO
    // is never bypassed to the transmitter in the same cycle. A pop frees a
    // slot, so a write landing on a full FIFO's pop edge is accepted.
    assign pop  = (state == IDLE) & enable & ~empty;
    assign push = data_wr & (~full | pop);

    // 4'() zero-extends shallow FIFOs and truncates the count of a full
    // 16-deep FIFO, where the full bit carries the information instead.
    assign status = {timeout_err, overflow, 4'(count), (state != IDLE), full};
    assign ctrl   = {6'b0, irq_en, enable};

    always_comb begin
        m_rd_data = 8'h00;
        if (m_addr == STATUS_ADDR)    m_rd_data = status;
        else if (m_addr == CTRL_ADDR) m_rd_data = ctrl;
    end

    assign irq = irq_en & empty & (state == IDLE);

    // ---- FIFO ----
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= m_wr_data;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- sequencer FSM ----
    always_comb begin
        state_nxt = state;
        tmo_fire  = 1'b0;
        case (state)
            IDLE:    if (pop) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                    // transmitter never took the byte; drop it and move on
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_LO: if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            tx_din   <= 8'h00;
            tx_wr_en <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            // high exactly while in LOAD
            tx_wr_en <= pop;
            if (pop) tx_din <= mem[rd_ptr];
            if (state == LOAD)         tmo_cnt <= '0;
            else if (state == WAIT_HI) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // ---- control / sticky flags ----
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            enable      <= 1'b1;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= m_wr_data[0];
                irq_en <= m_wr_data[1];
                if (m_wr_data[7]) begin
                    overflow    <= 1'b0;
                    timeout_err <= 1'b0;
                end
            end
            // a new event in the same cycle as a clear wins, so it is not lost
            if (data_wr & full & ~pop) overflow    <= 1'b1;
            if (tmo_fire)              timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural transmitter model that
// records every started byte.
module tb_uart_tx_ctrl;

    localparam logic [10:0] A_DATA = 11'd101;
    localparam logic [10:0] A_STAT = 11'd102;
    localparam logic [10:0] A_CTRL = 11'd103;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [10:0] m_addr = '0;
    logic [7:0]  m_wr_data = '0;
    logic        m_wr = 1'b0, m_rd = 1'b0, m_en = 1'b0;
    logic [7:0]  m_rd_data, tx_din;
    logic        rd_hit, tx_wr_en, tx_busy, irq;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl dut (
        .clk(clk), .reset_(reset_), .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_wr(m_wr), .m_rd(m_rd), .m_en(m_en), .m_rd_data(m_rd_data),
        .rd_hit(rd_hit), .tx_din(tx_din), .tx_wr_en(tx_wr_en),
        .tx_busy(tx_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    // transmitter model: busy rises the edge after tx_wr_en, stays high
    // busy_len extra cycles, or indefinitely while busy_hold is set
    logic       busy_hold = 1'b0;
    logic       busy_never = 1'b0;
    int         busy_len = 5;
    int         bcnt;
    logic [7:0] sent_q[$];

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_wr_en) begin
            sent_q.push_back(tx_din);
            if (!busy_never) begin
                tx_busy <= 1'b1;
                bcnt    <= busy_len;
            end
        end else if (tx_busy) begin
            if (bcnt > 0)        bcnt <= bcnt - 1;
            else if (!busy_hold) tx_busy <= 1'b0;
        end
    end

    function automatic logic [7:0] sent_at(input int i);
        if (i < sent_q.size()) return sent_q[i];
        return 8'hxx;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [7:0] d);
        m_en = 1'b1; m_wr = 1'b1; m_addr = a; m_wr_data = d;
        @(negedge clk);
        m_en = 1'b0; m_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [10:0] a, output logic [7:0] d, output logic hit);
        m_en = 1'b1; m_rd = 1'b1; m_addr = a;
        #1;
        d = m_rd_data; hit = rd_hit;
        m_en = 1'b0; m_rd = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [10:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       h;
        bus_read(a, d, h);
        check(tag, d, exp);
    endtask

    // bounded poll of STATUS; an expired budget shows up as a failed check
    task automatic wait_status(input string tag, input logic [7:0] exp, input int budget);
        logic [7:0] d;
        logic       h;
        bus_read(A_STAT, d, h);
        for (int i = 0; i < budget && d !== exp; i++) begin
            @(negedge clk);
            bus_read(A_STAT, d, h);
        end
        check(tag, d, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic       h;
        int         n0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_wr_en", {7'b0, tx_wr_en}, 8'h00);
        check("rst_din", tx_din, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check_reg("rst_status", A_STAT, 8'h00);
        check_reg("rst_ctrl", A_CTRL, 8'h01);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        bus_read(A_DATA, d, h);
        check("data_rd_hit", {7'b0, h}, 8'h00);
        bus_read(A_STAT, d, h);
        check("stat_rd_hit", {7'b0, h}, 8'h01);
        @(negedge clk);

        // ---- single byte, latency and pulse width ----
        n0 = sent_q.size();
        bus_write(A_DATA, 8'h48);
        check("lat_wr_en_c1", {7'b0, tx_wr_en}, 8'h00);
        @(negedge clk);
        check("lat_wr_en_c2", {7'b0, tx_wr_en}, 8'h01);
        check("lat_din", tx_din, 8'h48);
        @(negedge clk);
        check("pulse_one_cycle", {7'b0, tx_wr_en}, 8'h00);
        check_reg("single_active", A_STAT, 8'h02);
        @(negedge clk);
        wait_status("single_done", 8'h00, 50);
        check("single_sent", sent_at(n0), 8'h48);

        // ---- burst with busy held: fill, overflow, ordered drain ----
        busy_hold = 1'b1;
        n0 = sent_q.size();
        bus_write(A_DATA, 8'h40);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) bus_write(A_DATA, 8'h41 + 8'(i));
        // count 8, active, full
        check_reg("burst_full", A_STAT, 8'h23);
        bus_write(A_DATA, 8'h49);
        check_reg("burst_ovf", A_STAT, 8'h63);
        busy_hold = 1'b0;
        wait_status("burst_drained", 8'h40, 400);
        check("burst_count", 8'(sent_q.size() - n0), 8'd9);
        for (int i = 0; i < 9; i++) check("burst_order", sent_at(n0 + i), 8'h40 + 8'(i));

        // ---- overflow clear via write-1-to-clear ----
        bus_write(A_CTRL, 8'h81);
        check_reg("ovf_clr_status", A_STAT, 8'h00);
        check_reg("ovf_clr_ctrl", A_CTRL, 8'h01);

        // ---- busy timeout: 16 WAIT_HI cycles, then IDLE ----
        busy_never = 1'b1;
        n0 = sent_q.size();
        bus_write(A_DATA, 8'h55);
        repeat (17) @(negedge clk);
        check_reg("tmo_last_wait", A_STAT, 8'h02);
        @(negedge clk);
        check_reg("tmo_fired", A_STAT, 8'h80);
        busy_never = 1'b0;
        bus_write(A_DATA, 8'h66);
        wait_status("tmo_next_done", 8'h80, 60);
        check("tmo_first", sent_at(n0), 8'h55);
        check("tmo_next", sent_at(n0 + 1), 8'h66);
        bus_write(A_CTRL, 8'h81);
        check_reg("tmo_clr", A_STAT, 8'h00);

        // ---- enable=0 holds bytes; push on the pop edge of a full FIFO ----
        n0 = sent_q.size();
        bus_write(A_CTRL, 8'h00);
        for (int i = 0; i < 8; i++) bus_write(A_DATA, 8'h50 + 8'(i));
        repeat (5) @(negedge clk);
        check_reg("dis_held", A_STAT, 8'h21);
        check("dis_nothing_sent", 8'(sent_q.size() - n0), 8'd0);
        bus_write(A_CTRL, 8'h01);
        bus_write(A_DATA, 8'h58);
        check_reg("pushpop_full", A_STAT, 8'h23);
        wait_status("pushpop_drained", 8'h00, 400);
        check("pushpop_count", 8'(sent_q.size() - n0), 8'd9);
        for (int i = 0; i < 9; i++) check("pushpop_order", sent_at(n0 + i), 8'h50 + 8'(i));

        // ---- irq ----
        bus_write(A_CTRL, 8'h03);
        #1;
        check("irq_idle", {7'b0, irq}, 8'h01);
        check_reg("irq_ctrl", A_CTRL, 8'h03);

        // ---- async reset mid-operation ----
        busy_hold = 1'b1;
        @(negedge clk);
        bus_write(A_DATA, 8'hA1);
        bus_write(A_DATA, 8'hA2);
        bus_write(A_DATA, 8'hA3);
        repeat (3) @(negedge clk);
        check("irq_busy", {7'b0, irq}, 8'h00);
        check_reg("pre_rst_status", A_STAT, 8'h0A);
        #3;
        reset_ = 1'b0;
        #1;
        check("mid_rst_wr_en", {7'b0, tx_wr_en}, 8'h00);
        check_reg("mid_rst_status", A_STAT, 8'h00);
        check_reg("mid_rst_ctrl", A_CTRL, 8'h01);
        busy_hold = 1'b0;
        n0 = sent_q.size();
        @(negedge clk);
        reset_ = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_nothing_sent", 8'(sent_q.size() - n0), 8'd0);
        check_reg("post_rst_status", A_STAT, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // absolute guard so the bench cannot hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
